// File: rtl/regbank_s2_arbiter.sv
// Round-robin arbiter sharing one RegBankS2 register bank between two instruction requesters.
// It forwards legal instructions as one-cycle pulses and routes RDO results back to the issuer.
module regbank_s2_arbiter #(
  parameter logic [3:0] OP_NOP = 4'h0,
  parameter logic [3:0] OP_RDO = 4'h1,
  parameter logic [3:0] OP_LD0 = 4'h2,
  parameter logic [3:0] OP_LD1 = 4'h3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [11:0] inst0,
  output logic        gnt0,
  output logic        err0,
  output logic        rvalid0,
  input  logic        req1,
  input  logic [11:0] inst1,
  output logic        gnt1,
  output logic        err1,
  output logic        rvalid1,
  output logic [7:0]  rdata,
  output logic [11:0] bank_inst,
  output logic        bank_inst_en,
  input  logic [7:0]  bank_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StRead} state_e;

  state_e      r_state;
  logic        r_prio;
  logic        r_owner;
  logic        r_is_rdo;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_err0;
  logic        r_err1;
  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [7:0]  r_rdata;
  logic [11:0] r_bank_inst;
  logic        r_bank_inst_en;

  logic        w_any_req;
  logic        w_winner;
  logic [11:0] w_inst;
  logic [3:0]  w_op;
  logic        w_legal;

  always_comb begin
    w_any_req = req0 | req1;
    // r_prio names the preferred requester; it only matters when both request.
    if (req0 && req1) begin
      w_winner = r_prio;
    end else begin
      w_winner = req1;
    end
    w_inst  = w_winner ? inst1 : inst0;
    w_op    = w_inst[11:8];
    w_legal = (w_op == OP_NOP) || (w_op == OP_RDO) || (w_op == OP_LD0) || (w_op == OP_LD1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_prio         <= 1'b0;
      r_owner        <= 1'b0;
      r_is_rdo       <= 1'b0;
      r_gnt0         <= 1'b0;
      r_gnt1         <= 1'b0;
      r_err0         <= 1'b0;
      r_err1         <= 1'b0;
      r_rvalid0      <= 1'b0;
      r_rvalid1      <= 1'b0;
      r_rdata        <= 8'h00;
      r_bank_inst    <= 12'h000;
      r_bank_inst_en <= 1'b0;
    end else begin
      r_gnt0         <= 1'b0;
      r_gnt1         <= 1'b0;
      r_err0         <= 1'b0;
      r_err1         <= 1'b0;
      r_rvalid0      <= 1'b0;
      r_rvalid1      <= 1'b0;
      r_bank_inst_en <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_bank_inst    <= w_inst;
            r_owner        <= w_winner;
            r_prio         <= ~w_winner;
            r_gnt0         <= ~w_winner;
            r_gnt1         <= w_winner;
            r_err0         <= ~w_winner & ~w_legal;
            r_err1         <= w_winner & ~w_legal;
            r_bank_inst_en <= w_legal;
            r_is_rdo       <= w_legal && (w_op == OP_RDO);
            r_state        <= StIssue;
          end
        end
        StIssue: begin
          r_state <= r_is_rdo ? StRead : StIdle;
        end
        StRead: begin
          r_rdata   <= bank_out;
          r_rvalid0 <= ~r_owner;
          r_rvalid1 <= r_owner;
          r_state   <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign gnt0         = r_gnt0;
  assign gnt1         = r_gnt1;
  assign err0         = r_err0;
  assign err1         = r_err1;
  assign rvalid0      = r_rvalid0;
  assign rvalid1      = r_rvalid1;
  assign rdata        = r_rdata;
  assign bank_inst    = r_bank_inst;
  assign bank_inst_en = r_bank_inst_en;

endmodule

// File: tb/tb_regbank_s2_arbiter.sv
// Bench for regbank_s2_arbiter: directed vector table, corner sequences, and random traffic
// checked every cycle against a transaction-level model with a behavioural register bank.
module tb_regbank_s2_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [11:0] inst0 = 12'h000;
  logic [11:0] inst1 = 12'h000;
  logic        gnt0, err0, rvalid0, gnt1, err1, rvalid1, bank_inst_en;
  logic [7:0]  rdata;
  logic [11:0] bank_inst;
  logic [7:0]  bank_out = 8'h00;

  always #5 clock = ~clock;

  regbank_s2_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .inst0       (inst0),
    .gnt0        (gnt0),
    .err0        (err0),
    .rvalid0     (rvalid0),
    .req1        (req1),
    .inst1       (inst1),
    .gnt1        (gnt1),
    .err1        (err1),
    .rvalid1     (rvalid1),
    .rdata       (rdata),
    .bank_inst   (bank_inst),
    .bank_inst_en(bank_inst_en),
    .bank_out    (bank_out)
  );

  // Behavioural RegBankS2: LD0/LD1 load a register, RDO presents one on bank_out.
  logic [7:0] b_reg0 = 8'h00;
  logic [7:0] b_reg1 = 8'h00;
  always @(posedge clock) begin
    if (bank_inst_en) begin
      case (bank_inst[11:8])
        4'h1: bank_out <= bank_inst[0] ? b_reg1 : b_reg0;
        4'h2: b_reg0 <= bank_inst[7:0];
        4'h3: b_reg1 <= bank_inst[7:0];
        default: ;
      endcase
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: busy cycles count down, results are scheduled ahead in time.
  int         m_busy;
  int         m_rv_cnt;
  logic       m_prio;
  logic       m_rv_who;
  logic [7:0] m_rv_data;
  logic [7:0] m_rdata;
  logic [7:0] m_reg [2];
  logic [11:0] m_bank_inst;
  logic [1:0] e_gnt, e_err, e_rv;
  logic       e_en;

  task automatic model_reset();
    m_busy = 0; m_rv_cnt = 0; m_prio = 1'b0; m_rv_who = 1'b0; m_rv_data = 8'h00;
    m_rdata = 8'h00; m_bank_inst = 12'h000;
    e_gnt = 2'b00; e_err = 2'b00; e_rv = 2'b00; e_en = 1'b0;
  endtask

  task automatic model_edge();
    logic        w;
    logic [11:0] ins;
    logic [3:0]  op;
    e_gnt = 2'b00; e_err = 2'b00; e_rv = 2'b00; e_en = 1'b0;
    if (m_rv_cnt > 0) begin
      m_rv_cnt--;
      if (m_rv_cnt == 0) begin
        e_rv[m_rv_who] = 1'b1;
        m_rdata = m_rv_data;
      end
    end
    if (m_busy > 0) begin
      m_busy--;
    end else if (req0 || req1) begin
      w = (req0 && req1) ? m_prio : req1;
      ins = w ? inst1 : inst0;
      op = ins[11:8];
      e_gnt[w] = 1'b1;
      m_bank_inst = ins;
      m_prio = ~w;
      m_busy = 1;
      if (op > 4'h3) begin
        e_err[w] = 1'b1;
      end else begin
        e_en = 1'b1;
        if (op == 4'h2) m_reg[0] = ins[7:0];
        else if (op == 4'h3) m_reg[1] = ins[7:0];
        else if (op == 4'h1) begin
          m_busy = 2;
          m_rv_cnt = 2;
          m_rv_who = w;
          m_rv_data = m_reg[ins[0]];
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    chk("gnt", 32'({gnt1, gnt0}), 32'(e_gnt));
    chk("err", 32'({err1, err0}), 32'(e_err));
    chk("bank_inst_en", 32'(bank_inst_en), 32'(e_en));
    chk("bank_inst", 32'(bank_inst), 32'(m_bank_inst));
    chk("rvalid", 32'({rvalid1, rvalid0}), 32'(e_rv));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pulses", 32'({gnt0, gnt1, err0, err1, rvalid0, rvalid1, bank_inst_en}), 32'd0);
    chk("rst_bank_inst", 32'(bank_inst), 32'h000);
    chk("rst_rdata", 32'(rdata), 32'h00);
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic        r0;
    logic [11:0] i0;
    logic        r1;
    logic [11:0] i1;
    logic [1:0]  eg;
    logic [1:0]  ee;
    logic        een;
    logic [11:0] ebi;
  } vec_t;

  vec_t        tbl [8];
  logic [11:0] seq [2];
  logic        pend [2];
  logic [11:0] pinst [2];

  function automatic logic [11:0] rand_inst();
    int unsigned sel;
    logic [3:0] op;
    sel = $urandom_range(0, 9);
    op = (sel < 8) ? 4'(sel % 4) : 4'($urandom_range(4, 15));
    return {op, 8'($urandom)};
  endfunction

  initial begin
    m_reg[0] = 8'h00;
    m_reg[1] = 8'h00;
    model_reset();

    // Reset and idle
    do_reset(5);
    repeat (3) step();
    chk("idle_bank_inst", 32'(bank_inst), 32'h000);

    // Directed grants: pointer alternation and illegal opcode
    tbl[0] = '{1'b1, 12'h2AE, 1'b0, 12'h000, 2'b01, 2'b00, 1'b1, 12'h2AE};
    tbl[1] = '{1'b0, 12'h000, 1'b1, 12'h355, 2'b10, 2'b00, 1'b1, 12'h355};
    tbl[2] = '{1'b1, 12'h211, 1'b1, 12'h322, 2'b01, 2'b00, 1'b1, 12'h211};
    tbl[3] = '{1'b0, 12'h000, 1'b1, 12'h322, 2'b10, 2'b00, 1'b1, 12'h322};
    tbl[4] = '{1'b1, 12'h233, 1'b0, 12'h000, 2'b01, 2'b00, 1'b1, 12'h233};
    tbl[5] = '{1'b1, 12'h244, 1'b1, 12'h366, 2'b10, 2'b00, 1'b1, 12'h366};
    tbl[6] = '{1'b1, 12'h244, 1'b0, 12'h000, 2'b01, 2'b00, 1'b1, 12'h244};
    tbl[7] = '{1'b0, 12'h000, 1'b1, 12'hFAB, 2'b10, 2'b10, 1'b0, 12'hFAB};
    for (int i = 0; i < 8; i++) begin
      req0 = tbl[i].r0; inst0 = tbl[i].i0;
      req1 = tbl[i].r1; inst1 = tbl[i].i1;
      step();
      chk("tbl_gnt", 32'({gnt1, gnt0}), 32'(tbl[i].eg));
      chk("tbl_err", 32'({err1, err0}), 32'(tbl[i].ee));
      chk("tbl_en", 32'(bank_inst_en), 32'(tbl[i].een));
      chk("tbl_bank_inst", 32'(bank_inst), 32'(tbl[i].ebi));
      req0 = 1'b0; req1 = 1'b0;
      step();
    end

    // Load then read back through requester 0
    req0 = 1'b1; inst0 = 12'h2AE;
    step();
    req0 = 1'b0;
    step();
    req0 = 1'b1; inst0 = 12'h100;
    step();
    chk("rdo_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    step();
    chk("rdo_no_early_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    step();
    chk("rdo_rvalid0", 32'(rvalid0), 32'd1);
    chk("rdo_rvalid1", 32'(rvalid1), 32'd0);
    chk("rdo_rdata", 32'(rdata), 32'hAE);
    step();
    chk("rdata_hold", 32'(rdata), 32'hAE);

    // Reset during the READ cycle discards the result
    req1 = 1'b1; inst1 = 12'h101;
    step();
    chk("rdo1_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    step();
    do_reset(2);
    step();
    chk("rst_no_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_no_en", 32'(bank_inst_en), 32'd0);
    req1 = 1'b1; inst1 = 12'h327;
    step();
    chk("post_rst_gnt1", 32'(gnt1), 32'd1);
    chk("post_rst_bank_inst", 32'(bank_inst), 32'h327);
    req1 = 1'b0;
    step();

    // Continuous requester 0: one grant every two cycles
    seq[0] = 12'h000; seq[1] = 12'h387;
    req0 = 1'b1; inst0 = seq[0];
    for (int k = 0; k < 6; k++) begin
      step();
      chk("b2b_gnt0", 32'(gnt0), 32'd1);
      chk("b2b_bank_inst", 32'(bank_inst), 32'(seq[k % 2]));
      inst0 = seq[(k + 1) % 2];
      step();
      chk("b2b_gap", 32'(gnt0), 32'd0);
    end
    req0 = 1'b0;
    step();
    step();

    // Random traffic from two contract-abiding requesters
    pend[0] = 1'b0; pend[1] = 1'b0;
    pinst[0] = 12'h000; pinst[1] = 12'h000;
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        logic g;
        g = (k == 0) ? gnt0 : gnt1;
        if (g) begin
          pend[k] = ($urandom % 2) == 0;
          if (pend[k]) pinst[k] = rand_inst();
        end else if (!pend[k] && ($urandom % 3) == 0) begin
          pend[k] = 1'b1;
          pinst[k] = rand_inst();
        end
      end
      req0 = pend[0]; inst0 = pinst[0];
      req1 = pend[1]; inst1 = pinst[1];
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
